// File: rtl/lbm_fp_pkg.sv
// Shared Q8.56 fixed-point types and constants for the LBM moment datapath.
// Build option LBM_ACCUM_SAT_EN selects saturating (defined) or wrapping (undefined) narrowing.
package lbm_fp_pkg;

    localparam int DATA_WIDTH      = 64;
    localparam int FRACTIONAL_BITS = 56;
    localparam int INTEGER_BITS    = DATA_WIDTH - FRACTIONAL_BITS;

    typedef logic signed [DATA_WIDTH-1:0] fixed_t;

    localparam fixed_t FP_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam fixed_t FP_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam fixed_t FP_ONE = fixed_t'(1) << FRACTIONAL_BITS;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } accum_state_t;

endpackage

// File: rtl/fp_sat_trunc.sv
// Narrows a wide two's-complement sum to OUT_W bits and flags overflow; combinational, no backpressure.
// LBM_ACCUM_SAT_EN defined: clamp to the signed OUT_W range on overflow; undefined: keep the low OUT_W bits.
module fp_sat_trunc #(
    parameter int IN_W  = 68,
    parameter int OUT_W = 64
) (
    input  logic [IN_W-1:0]  din,
    output logic [OUT_W-1:0] dout,
    output logic             ovf
);

    // The sum fits only if every bit above the result's sign bit agrees with it.
    logic [IN_W-OUT_W:0] top_bits;

    always_comb begin
        top_bits = din[IN_W-1:OUT_W-1];
        ovf      = !((&top_bits) || !(|top_bits));
`ifdef LBM_ACCUM_SAT_EN
        if (ovf) begin
            dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
            dout = din[OUT_W-1:0];
        end
`else
        dout = din[OUT_W-1:0];
`endif
    end

endmodule

// File: rtl/lbm_moment_accum.sv
// Sums NUM_TERMS signed Q8.56 products per frame into one moment; result valid 1 cycle after the last term.
// in_ready follows out_ready while a finished moment waits, so a held output stalls the next frame.
module lbm_moment_accum
    import lbm_fp_pkg::*;
#(
    parameter int DATA_WIDTH      = lbm_fp_pkg::DATA_WIDTH,
    parameter int FRACTIONAL_BITS = lbm_fp_pkg::FRACTIONAL_BITS,
    parameter int NUM_TERMS       = 9
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_ovf
);

    localparam int GUARD_BITS = $clog2(NUM_TERMS);
    localparam int ACC_W      = DATA_WIDTH + GUARD_BITS;
    localparam int CNT_W      = $clog2(NUM_TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_TERMS - 1);

    accum_state_t          state_q, state_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_ovf_q, out_ovf_d;

    logic                  accept;
    logic                  emit;
    logic [ACC_W-1:0]      in_ext;
    logic [ACC_W-1:0]      sum_w;
    logic [DATA_WIDTH-1:0] trunc_data;
    logic                  trunc_ovf;

    assign in_ready = (state_q == DONE) ? out_ready : 1'b1;
    assign accept   = in_valid & in_ready;
    assign emit     = out_valid_q & out_ready;
    assign in_ext   = {{GUARD_BITS{in_data[DATA_WIDTH-1]}}, in_data};
    assign sum_w    = acc_q + in_ext;

    fp_sat_trunc #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_WIDTH)
    ) u_sat_trunc (
        .din  (sum_w),
        .dout (trunc_data),
        .ovf  (trunc_ovf)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d   = in_ext;
                    cnt_d   = CNT_W'(1);
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (accept) begin
                    acc_d = sum_w;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        out_data_d  = trunc_data;
                        out_ovf_d   = trunc_ovf;
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            DONE: begin
                // An accept here implies emit, since in_ready mirrors out_ready.
                if (emit) begin
                    out_valid_d = 1'b0;
                    if (accept) begin
                        acc_d   = in_ext;
                        cnt_d   = CNT_W'(1);
                        state_d = ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_lbm_moment_accum.sv
// Scoreboard bench for lbm_moment_accum: expected moments queued at stimulus, compared on each emit.
// Honours LBM_ACCUM_SAT_EN the same way as the RTL build.
module tb_lbm_moment_accum;

    localparam logic [63:0] ONE    = 64'h0100_0000_0000_0000;
    localparam logic [63:0] NEG1   = 64'hFF00_0000_0000_0000;
    localparam logic [63:0] P2_5   = 64'h0280_0000_0000_0000;
    localparam logic [63:0] M2_625 = 64'hFD60_0000_0000_0000;
    localparam logic [63:0] MAXV   = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] MINV   = 64'h8000_0000_0000_0000;

    typedef struct {
        logic [63:0] data;
        logic        ovf;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_ovf;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    lbm_moment_accum dut (
        .Clk       (clk),
        .Reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    endtask

    // Reference: exact wide sum, then overflow test and wrap/clamp on the signed 64-bit range.
    function automatic exp_t model(input logic [63:0] t[9], input string tag);
        logic signed [67:0] s;
        logic signed [67:0] lim_hi;
        logic signed [67:0] lim_lo;
        exp_t e;
        s      = '0;
        lim_hi = 68'sh0_7FFF_FFFF_FFFF_FFFF;
        lim_lo = -68'sh0_8000_0000_0000_0000;
        for (int i = 0; i < 9; i++) s = s + $signed({{4{t[i][63]}}, t[i]});
        e.ovf  = (s > lim_hi) || (s < lim_lo);
`ifdef LBM_ACCUM_SAT_EN
        e.data = e.ovf ? ((s < 0) ? MINV : MAXV) : s[63:0];
`else
        e.data = s[63:0];
`endif
        e.tag  = tag;
        return e;
    endfunction

    // Offers one term after 0..max_gap idle cycles; returns at posedge+1 after it is accepted.
    task automatic send(input logic [63:0] d, input int max_gap);
        int g;
        int waited;
        g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        in_valid = 1'b0;
        repeat (g) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check_eq("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input logic [63:0] t[9], input int max_gap,
                             input logic [63:0] exp_data, input logic exp_ovf);
        exp_t e;
        e.data = exp_data;
        e.ovf  = exp_ovf;
        e.tag  = tag;
        sb.push_back(e);
        for (int i = 0; i < 9; i++) send(t[i], max_gap);
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        if (sb.size() != 0) check_eq("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_output", out_data, 64'hDEAD_DEAD_DEAD_DEAD);
                end else begin
                    e = sb.pop_front();
                    check_eq({e.tag, "_data"}, out_data, e.data);
                    check_eq({e.tag, "_ovf"}, 64'(out_ovf), 64'(e.ovf));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [63:0] t[9];
        exp_t        e;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data", out_data, 64'd0);
        check_eq("rst_out_ovf", 64'(out_ovf), 64'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);

        // 1: nine 1.0 back to back
        for (int i = 0; i < 9; i++) t[i] = ONE;
        run_frame("t1", t, 0, 64'h0900_0000_0000_0000, 1'b0);
        check_eq("t1_latency", 64'(out_valid), 64'd1);
        wait_drain();

        // 2: nine -1.0
        for (int i = 0; i < 9; i++) t[i] = NEG1;
        run_frame("t2", t, 0, 64'hF700_0000_0000_0000, 1'b0);
        wait_drain();

        // 3: 8 x 2.5 + -2.625, then again with random input gaps
        for (int i = 0; i < 8; i++) t[i] = P2_5;
        t[8] = M2_625;
        run_frame("t3", t, 0, 64'h1160_0000_0000_0000, 1'b0);
        run_frame("t3_gaps", t, 3, 64'h1160_0000_0000_0000, 1'b0);
        wait_drain();

        // 4: positive overflow
        for (int i = 0; i < 9; i++) t[i] = MAXV;
`ifdef LBM_ACCUM_SAT_EN
        run_frame("t4", t, 0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
`else
        run_frame("t4", t, 0, 64'h7FFF_FFFF_FFFF_FFF7, 1'b1);
`endif
        // negative overflow: -9 * 2^63 wraps and clamps to the same pattern
        for (int i = 0; i < 9; i++) t[i] = MINV;
        run_frame("t4_neg", t, 0, 64'h8000_0000_0000_0000, 1'b1);
        // exact range edges are not overflow
        for (int i = 0; i < 9; i++) t[i] = 64'd0;
        t[4] = MAXV;
        run_frame("edge_max", t, 0, MAXV, 1'b0);
        t[4] = MINV;
        run_frame("edge_min", t, 0, MINV, 1'b0);
        wait_drain();

        // 5: output held for 5 cycles, then same-cycle emit + accept
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++) t[i] = ONE;
        run_frame("t5a", t, 0, 64'h0900_0000_0000_0000, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check_eq("t5_hold_valid", 64'(out_valid), 64'd1);
            check_eq("t5_hold_data", out_data, 64'h0900_0000_0000_0000);
            check_eq("t5_hold_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        run_frame("t5b", t, 0, 64'h0900_0000_0000_0000, 1'b0);
        wait_drain();

        // 6: reset mid-frame discards the partial sum
        for (int i = 0; i < 4; i++) send(ONE, 0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_eq("t6_rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("t6_rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("t6_rst_out_data", out_data, 64'd0);
        run_frame("t6", t, 0, 64'h0900_0000_0000_0000, 1'b0);
        wait_drain();

        // random full-range frames (often overflowing) and scaled-down frames (never overflowing)
        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 9; i++) begin
                t[i] = {$urandom, $urandom};
                if (f >= 3) t[i] = $signed(t[i]) >>> 4;
            end
            e = model(t, $sformatf("rnd%0d", f));
            run_frame(e.tag, t, 2, e.data, e.ovf);
        end
        wait_drain();
        check_eq("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
